// File: rtl/id_ex_pipe_pkg.sv
// Shared widths, ID->EX payload type and bubble constant for the ID->EX pipeline register.
package id_ex_pipe_pkg;

  localparam int unsigned REG_LOG = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTRL_W  = 16;
  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned CNT_W   = 32;

  localparam logic [REG_LOG-1:0] ZERO_REG = '0;
  localparam logic [CTRL_W-1:0]  CTRL_NOP = '0;

  typedef struct packed {
    logic                        valid;
    logic [NUM_SRC*REG_LOG-1:0]  rs;
    logic [REG_LOG-1:0]          rd;
    logic                        reg_write;
    logic                        mem_read;
    logic [NUM_SRC*DATA_W-1:0]   opnd;
    logic [DATA_W-1:0]           imm;
    logic [CTRL_W-1:0]           ctrl;
  } id_ex_t;

  typedef enum logic [1:0] {
    SEL_LOAD   = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BUBBLE = 2'd2,
    SEL_FLUSH  = 2'd3
  } ex_sel_e;

  // All-zero payload so forwarding/interlock can never match a bubble.
  function automatic id_ex_t bubble_pkt();
    id_ex_t b;
    b      = '0;
    b.ctrl = CTRL_NOP;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_pipe_load_use_detect.sv
// Combinational load-use hazard detector: ID source read vs. load destination sitting in EX.
module id_ex_pipe_load_use_detect
  import id_ex_pipe_pkg::*;
(
  input  logic                       valid_ID,
  input  logic [NUM_SRC*REG_LOG-1:0] rs_ID,
  input  logic [NUM_SRC-1:0]         rs_used_ID,
  input  logic                       valid_EX,
  input  logic                       MEM_read_EX,
  input  logic [REG_LOG-1:0]         rd_EX,
  output logic                       hz
);

  logic [NUM_SRC-1:0] match;

  // Source g lives at the g-th field from the MSB ({rs0,rs1,rs2}, {u0,u1,u2}).
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign match[g] = rs_used_ID[NUM_SRC-1-g] &
                      (rs_ID[(NUM_SRC-g)*REG_LOG-1 -: REG_LOG] == rd_EX);
  end

  assign hz = valid_ID & valid_EX & MEM_read_EX & (rd_EX != ZERO_REG) & (|match);

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with load-use interlock, bubble injection and EX flush.
// Optional perf counters (bubble_cnt, flush_cnt) when ID_EX_PERF_CNT_EN is defined.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       valid_ID,
  input  logic [NUM_SRC*REG_LOG-1:0] rs_ID,
  input  logic [NUM_SRC-1:0]         rs_used_ID,
  input  logic [REG_LOG-1:0]         rd_ID,
  input  logic                       REG_write_ID,
  input  logic                       MEM_read_ID,
  input  logic [NUM_SRC*DATA_W-1:0]  opnd_ID,
  input  logic [DATA_W-1:0]          imm_ID,
  input  logic [CTRL_W-1:0]          ctrl_ID,
  input  logic                       flush_EX,
  input  logic                       stall_ext,
  output logic                       valid_EX,
  output logic [NUM_SRC*REG_LOG-1:0] rs_EX,
  output logic [REG_LOG-1:0]         rd_EX,
  output logic                       REG_write_EX,
  output logic                       MEM_read_EX,
  output logic [NUM_SRC*DATA_W-1:0]  opnd_EX,
  output logic [DATA_W-1:0]          imm_EX,
  output logic [CTRL_W-1:0]          ctrl_EX,
  output logic                       stall_ID
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]           bubble_cnt,
  output logic [CNT_W-1:0]           flush_cnt
`endif
);

  id_ex_t  ex_q;
  id_ex_t  ex_d;
  id_ex_t  id_pkt;
  ex_sel_e sel;
  logic    hz;

  id_ex_pipe_load_use_detect u_lud (
    .valid_ID    (valid_ID),
    .rs_ID       (rs_ID),
    .rs_used_ID  (rs_used_ID),
    .valid_EX    (ex_q.valid),
    .MEM_read_EX (ex_q.mem_read),
    .rd_EX       (ex_q.rd),
    .hz          (hz)
  );

  assign stall_ID = (hz & ~flush_EX) | stall_ext;

  always_comb begin
    id_pkt.valid     = 1'b1;
    id_pkt.rs        = rs_ID;
    id_pkt.rd        = rd_ID;
    id_pkt.reg_write = REG_write_ID;
    id_pkt.mem_read  = MEM_read_ID;
    id_pkt.opnd      = opnd_ID;
    id_pkt.imm       = imm_ID;
    id_pkt.ctrl      = ctrl_ID;
  end

  // Priority: flush > external stall > load-use bubble > normal advance.
  always_comb begin
    sel = SEL_LOAD;
    if (flush_EX)       sel = SEL_FLUSH;
    else if (stall_ext) sel = SEL_HOLD;
    else if (hz)        sel = SEL_BUBBLE;
  end

  always_comb begin
    ex_d = ex_q;
    unique case (sel)
      SEL_FLUSH, SEL_BUBBLE: ex_d = bubble_pkt();
      SEL_HOLD:              ex_d = ex_q;
      default:               ex_d = valid_ID ? id_pkt : bubble_pkt();
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign valid_EX     = ex_q.valid;
  assign rs_EX        = ex_q.rs;
  assign rd_EX        = ex_q.rd;
  assign REG_write_EX = ex_q.reg_write & ex_q.valid;
  assign MEM_read_EX  = ex_q.mem_read & ex_q.valid;
  assign opnd_EX      = ex_q.opnd;
  assign imm_EX       = ex_q.imm;
  assign ctrl_EX      = ex_q.ctrl;

`ifdef ID_EX_PERF_CNT_EN
  // Flushes count only when they kill a real instruction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (sel == SEL_BUBBLE)              bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (sel == SEL_FLUSH && ex_q.valid) flush_cnt  <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe (perf checks under ID_EX_PERF_CNT_EN).
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid_ID;
  logic [14:0] rs_ID;
  logic [2:0]  rs_used_ID;
  logic [4:0]  rd_ID;
  logic        REG_write_ID;
  logic        MEM_read_ID;
  logic [95:0] opnd_ID;
  logic [31:0] imm_ID;
  logic [15:0] ctrl_ID;
  logic        flush_EX;
  logic        stall_ext;
  logic        valid_EX;
  logic [14:0] rs_EX;
  logic [4:0]  rd_EX;
  logic        REG_write_EX;
  logic        MEM_read_EX;
  logic [95:0] opnd_EX;
  logic [31:0] imm_EX;
  logic [15:0] ctrl_EX;
  logic        stall_ID;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_bubble = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rstn(rstn), .valid_ID(valid_ID), .rs_ID(rs_ID), .rs_used_ID(rs_used_ID),
    .rd_ID(rd_ID), .REG_write_ID(REG_write_ID), .MEM_read_ID(MEM_read_ID),
    .opnd_ID(opnd_ID), .imm_ID(imm_ID), .ctrl_ID(ctrl_ID), .flush_EX(flush_EX),
    .stall_ext(stall_ext), .valid_EX(valid_EX), .rs_EX(rs_EX), .rd_EX(rd_EX),
    .REG_write_EX(REG_write_EX), .MEM_read_EX(MEM_read_EX), .opnd_EX(opnd_EX),
    .imm_EX(imm_EX), .ctrl_EX(ctrl_EX), .stall_ID(stall_ID)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  function automatic logic [95:0] pat_opnd(input logic [31:0] s);
    return {s, ~s, s + 32'd1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [2:0] used, input logic [4:0] rd,
                        input logic regw, input logic memr, input logic [31:0] seed);
    valid_ID     = v;
    rs_ID        = {r0, r1, r2};
    rs_used_ID   = used;
    rd_ID        = rd;
    REG_write_ID = regw;
    MEM_read_ID  = memr;
    opnd_ID      = pat_opnd(seed);
    imm_ID       = seed ^ 32'h0000_5555;
    ctrl_ID      = seed[15:0];
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush_EX = 1'b0; stall_ext = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 3'b110, 5'd3, 1'b1, 1'b0, 32'hA0A0_0001);
    #2;
    checks++;
    if (valid_EX !== 1'b0 || rd_EX !== 5'd0 || opnd_EX !== 96'd0 || ctrl_EX !== 16'd0) begin
      errors++; $display("FAIL reset_init: valid=%b rd=%0d ctrl=%h, want 0", valid_EX, rd_EX, ctrl_EX);
    end
    @(posedge clk); #1 rstn = 1'b1;
    step();
    checks++;
    if (valid_EX !== 1'b1 || rd_EX !== 5'd3 || REG_write_EX !== 1'b1 ||
        opnd_EX !== pat_opnd(32'hA0A0_0001) || ctrl_EX !== 16'h0001 ||
        imm_EX !== 32'hA0A0_5554 || rs_EX !== {5'd1, 5'd2, 5'd0}) begin
      errors++; $display("FAIL reset_first_load: valid=%b rd=%0d imm=%h, want 1 3 a0a05554", valid_EX, rd_EX, imm_EX);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (valid_EX !== 1'b0 || rd_EX !== 5'd0 || REG_write_EX !== 1'b0 || opnd_EX !== 96'd0 ||
        imm_EX !== 32'd0 || rs_EX !== 15'd0) begin
      errors++; $display("FAIL reset_async: valid=%b rd=%0d imm=%h, want 0", valid_EX, rd_EX, imm_EX);
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: bubble=%0d flush=%0d, want 0", bubble_cnt, flush_cnt);
    end
`endif
    #1 rstn = 1'b1;
    step();
    checks++;
    if (valid_EX !== 1'b1 || rd_EX !== 5'd3) begin
      errors++; $display("FAIL reset_reload: valid=%b rd=%0d, want 1 3", valid_EX, rd_EX);
    end
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd5, 1'b1, 1'b1, 32'h0000_0050);
    step();
    checks++;
    if (valid_EX !== 1'b1 || MEM_read_EX !== 1'b1 || rd_EX !== 5'd5) begin
      errors++; $display("FAIL lu_load_in_ex: valid=%b memrd=%b rd=%0d, want 1 1 5", valid_EX, MEM_read_EX, rd_EX);
    end
    set_id(1'b1, 5'd5, 5'd0, 5'd0, 3'b100, 5'd6, 1'b1, 1'b0, 32'h0000_0100);
    #1;
    checks++;
    if (stall_ID !== 1'b1) begin
      errors++; $display("FAIL lu_stall: stall_ID=%b, want 1", stall_ID);
    end
    step(); exp_bubble++;
    checks++;
    if (valid_EX !== 1'b0 || MEM_read_EX !== 1'b0 || REG_write_EX !== 1'b0 ||
        rd_EX !== 5'd0 || rs_EX !== 15'd0 || stall_ID !== 1'b0) begin
      errors++; $display("FAIL lu_bubble: valid=%b rd=%0d rs=%h stall=%b, want 0 0 0 0", valid_EX, rd_EX, rs_EX, stall_ID);
    end
    step();
    checks++;
    if (valid_EX !== 1'b1 || rd_EX !== 5'd6 || rs_EX !== {5'd5, 5'd0, 5'd0} ||
        opnd_EX !== pat_opnd(32'h0000_0100) || MEM_read_EX !== 1'b0) begin
      errors++; $display("FAIL lu_dependent_enters: valid=%b rd=%0d rs=%h, want 1 6 1400", valid_EX, rd_EX, rs_EX);
    end
  endtask

  task automatic test_no_false_hazard();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b1, 32'h0000_0200);
    step();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 3'b111, 5'd8, 1'b1, 1'b0, 32'h0000_0201);
    #1;
    checks++;
    if (stall_ID !== 1'b0) begin
      errors++; $display("FAIL nf_ld_r0: stall_ID=%b, want 0", stall_ID);
    end
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd5, 1'b1, 1'b1, 32'h0000_0202);
    step();
    set_id(1'b1, 5'd0, 5'd5, 5'd0, 3'b100, 5'd9, 1'b1, 1'b0, 32'h0000_0203);
    #1;
    checks++;
    if (stall_ID !== 1'b0) begin
      errors++; $display("FAIL nf_unused_src: stall_ID=%b, want 0", stall_ID);
    end
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 3'b001, 5'd9, 1'b1, 1'b0, 32'h0000_0204);
    #1;
    checks++;
    if (stall_ID !== 1'b1) begin
      errors++; $display("FAIL nf_rs2_hazard: stall_ID=%b, want 1", stall_ID);
    end
    set_id(1'b0, 5'd0, 5'd0, 5'd5, 3'b001, 5'd9, 1'b1, 1'b0, 32'h0000_0205);
    #1;
    checks++;
    if (stall_ID !== 1'b0) begin
      errors++; $display("FAIL nf_invalid_id: stall_ID=%b, want 0", stall_ID);
    end
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd5, 1'b1, 1'b0, 32'h0000_0206);
    step();
    set_id(1'b1, 5'd5, 5'd5, 5'd5, 3'b111, 5'd10, 1'b1, 1'b0, 32'h0000_0207);
    #1;
    checks++;
    if (stall_ID !== 1'b0) begin
      errors++; $display("FAIL nf_alu_r5: stall_ID=%b, want 0", stall_ID);
    end
  endtask

  task automatic test_flush();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd5, 1'b1, 1'b1, 32'h0000_0300);
    step();
    set_id(1'b1, 5'd5, 5'd0, 5'd0, 3'b100, 5'd11, 1'b1, 1'b0, 32'h0000_0301);
    stall_ext = 1'b1; flush_EX = 1'b1;
    #1;
    checks++;
    if (stall_ID !== 1'b1) begin
      errors++; $display("FAIL fl_stall_from_ext: stall_ID=%b, want 1", stall_ID);
    end
    step(); exp_flush++;
    checks++;
    if (valid_EX !== 1'b0 || rd_EX !== 5'd0 || MEM_read_EX !== 1'b0 || REG_write_EX !== 1'b0) begin
      errors++; $display("FAIL fl_priority: valid=%b rd=%0d, want 0 0", valid_EX, rd_EX);
    end
    stall_ext = 1'b0;
    step();
    checks++;
    if (valid_EX !== 1'b0 || stall_ID !== 1'b0) begin
      errors++; $display("FAIL fl_idle_flush: valid=%b stall=%b, want 0 0", valid_EX, stall_ID);
    end
    flush_EX = 1'b0;
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd5, 1'b1, 1'b1, 32'h0000_0302);
    step();
    set_id(1'b1, 5'd5, 5'd0, 5'd0, 3'b100, 5'd11, 1'b1, 1'b0, 32'h0000_0303);
    flush_EX = 1'b1;
    #1;
    checks++;
    if (stall_ID !== 1'b0) begin
      errors++; $display("FAIL fl_masks_hz: stall_ID=%b, want 0", stall_ID);
    end
    step(); exp_flush++;
    flush_EX = 1'b0;
  endtask

  task automatic test_stall_ext();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 3'b111, 5'd7, 1'b1, 1'b0, 32'hCAFE_0007);
    step();
    stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd4, 5'd4, 5'd4, 3'b111, 5'(12 + i), 1'b0, 1'b1, 32'h1234_0000 + 32'(i));
      step();
      checks++;
      if (valid_EX !== 1'b1 || rd_EX !== 5'd7 || REG_write_EX !== 1'b1 || MEM_read_EX !== 1'b0 ||
          rs_EX !== {5'd1, 5'd2, 5'd3} || opnd_EX !== pat_opnd(32'hCAFE_0007) ||
          imm_EX !== 32'hCAFE_5552 || ctrl_EX !== 16'h0007 || stall_ID !== 1'b1) begin
        errors++; $display("FAIL se_hold_%0d: valid=%b rd=%0d imm=%h stall=%b, want 1 7 cafe5552 1", i, valid_EX, rd_EX, imm_EX, stall_ID);
      end
    end
    stall_ext = 1'b0;
    step();
    checks++;
    if (rd_EX !== 5'd14 || MEM_read_EX !== 1'b1) begin
      errors++; $display("FAIL se_release: rd=%0d memrd=%b, want 14 1", rd_EX, MEM_read_EX);
    end
  endtask

  task automatic test_back_to_back();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd1, 1'b1, 1'b1, 32'h0000_0400);
    step();
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 3'b100, 5'd2, 1'b1, 1'b1, 32'h0000_0401);
    #1;
    checks++;
    if (stall_ID !== 1'b1) begin
      errors++; $display("FAIL b2b_stall1: stall_ID=%b, want 1", stall_ID);
    end
    step(); exp_bubble++;
    checks++;
    if (valid_EX !== 1'b0 || stall_ID !== 1'b0) begin
      errors++; $display("FAIL b2b_bubble1: valid=%b stall=%b, want 0 0", valid_EX, stall_ID);
    end
    step();
    set_id(1'b1, 5'd0, 5'd2, 5'd0, 3'b010, 5'd3, 1'b1, 1'b0, 32'h0000_0402);
    #1;
    checks++;
    if (valid_EX !== 1'b1 || rd_EX !== 5'd2 || MEM_read_EX !== 1'b1 || stall_ID !== 1'b1) begin
      errors++; $display("FAIL b2b_stall2: valid=%b rd=%0d stall=%b, want 1 2 1", valid_EX, rd_EX, stall_ID);
    end
    step(); exp_bubble++;
    checks++;
    if (valid_EX !== 1'b0 || stall_ID !== 1'b0) begin
      errors++; $display("FAIL b2b_bubble2: valid=%b stall=%b, want 0 0", valid_EX, stall_ID);
    end
    step();
    checks++;
    if (valid_EX !== 1'b1 || rd_EX !== 5'd3 || rs_EX !== {5'd0, 5'd2, 5'd0}) begin
      errors++; $display("FAIL b2b_final: valid=%b rd=%0d rs=%h, want 1 3 0040", valid_EX, rd_EX, rs_EX);
    end
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_perf();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd9, 1'b1, 1'b1, 32'h0000_0500);
    step();
    set_id(1'b1, 5'd9, 5'd0, 5'd0, 3'b100, 5'd4, 1'b1, 1'b0, 32'h0000_0501);
    step(); exp_bubble++;
    step();
    checks++;
    if (bubble_cnt !== 32'(exp_bubble) || flush_cnt !== 32'(exp_flush)) begin
      errors++; $display("FAIL perf_counts: bubble=%0d flush=%0d, want %0d %0d", bubble_cnt, flush_cnt, exp_bubble, exp_flush);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_stall_ext();
    test_back_to_back();
`ifdef ID_EX_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
